// File: rtl/fp_writeback_collector_pkg.sv
// fp_writeback_collector_pkg: shared widths, vector types and writeback entry layout
package fp_writeback_collector_pkg;
  localparam int REG_BITS = 5;
  localparam int VEC_WIDTH = 4;
  localparam int FP_LATENCY_DEFAULT = 4;
  typedef logic [31:0] Scalar_t;
  typedef Scalar_t [VEC_WIDTH-1:0] Vector_t;
  typedef struct packed {
    logic [REG_BITS-1:0] dst_reg;
    logic dst_type;
    logic [VEC_WIDTH-1:0] mask;
    Vector_t data;
  } WbEntry_t;
  typedef struct packed {
    logic valid;
    logic [REG_BITS-1:0] dst_reg;
    logic dst_type;
    logic [VEC_WIDTH-1:0] mask;
  } meta_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: power-of-two result buffer; pointers wrap naturally at DEPTH
module wb_result_fifo
  import fp_writeback_collector_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  WbEntry_t push_data,
  output WbEntry_t head,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  WbEntry_t mem_q [DEPTH];
  WbEntry_t mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign count = count_q;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign head = empty ? '0 : mem_q[rd_ptr_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/fp_writeback_collector.sv
// fp_writeback_collector: tracks FP destination metadata alongside the FP pipe and buffers results for writeback
module fp_writeback_collector
  import fp_writeback_collector_pkg::*;
#(
  parameter int FP_LATENCY = FP_LATENCY_DEFAULT,
  parameter int BUF_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issueValid,
  output logic issueReady,
  input  logic [REG_BITS-1:0] issueDstReg,
  input  logic issueDstType,
  input  logic [VEC_WIDTH-1:0] issueMask,
  output logic fpStall,
  input  Vector_t fpResult,
  output logic wbValid,
  input  logic wbReady,
  output logic [REG_BITS-1:0] wbDstReg,
  output logic wbDstType,
  output logic [VEC_WIDTH-1:0] wbMask,
  output Vector_t wbData,
  output logic busy
);
  meta_t stage_q [FP_LATENCY];
  meta_t stage_d [FP_LATENCY];
  meta_t tail;
  WbEntry_t push_entry, head;
  logic [$clog2(BUF_DEPTH):0] count;
  logic full, empty, push, any_valid;
  assign tail = stage_q[FP_LATENCY-1];
  // Stall only when the tail has somewhere to go but the buffer is full (registered count)
  assign fpStall = tail.valid && full;
  assign issueReady = !fpStall;
  assign push = tail.valid && !fpStall && (tail.mask != '0);
  assign push_entry = {tail.dst_reg, tail.dst_type, tail.mask, fpResult};
  assign wbValid = !empty;
  assign wbDstReg = head.dst_reg;
  assign wbDstType = head.dst_type;
  assign wbMask = head.mask;
  assign wbData = head.data;
  assign busy = any_valid || (count != '0);
  always_comb begin
    stage_d = stage_q;
    if (!fpStall) begin
      stage_d[0].valid = issueValid;
      stage_d[0].dst_reg = issueDstReg;
      stage_d[0].dst_type = issueDstType;
      stage_d[0].mask = issueMask;
      for (int i = 1; i < FP_LATENCY; i++) stage_d[i] = stage_q[i-1];
    end
  end
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < FP_LATENCY; i++) any_valid = any_valid | stage_q[i].valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FP_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end
  wb_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(wbValid && wbReady),
    .push_data(push_entry),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_fp_writeback_collector.sv
// tb_fp_writeback_collector: directed checks of issue tracking, buffering, stall, drain and reset
module tb_fp_writeback_collector;
  import fp_writeback_collector_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issueValid = 1'b0;
  logic issueDstType = 1'b0;
  logic wbReady = 1'b0;
  logic [REG_BITS-1:0] issueDstReg = '0;
  logic [VEC_WIDTH-1:0] issueMask = '0;
  Vector_t issue_data = '0;
  Vector_t fpResult, wbData;
  logic issueReady, fpStall, wbValid, wbDstType, busy;
  logic [REG_BITS-1:0] wbDstReg;
  logic [VEC_WIDTH-1:0] wbMask;
  Vector_t fp_pipe [4];
  int tests = 0;
  int fails = 0;
  int k, wb_seen, stale;

  always #5 clk = ~clk;

  // Behavioural stand-in for the 4-cycle FP unit, stalled by the collector
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fp_pipe[i] <= '0;
    end else if (!fpStall) begin
      fp_pipe[0] <= (issueValid && issueReady) ? issue_data : '0;
      for (int i = 1; i < 4; i++) fp_pipe[i] <= fp_pipe[i-1];
    end
  end
  assign fpResult = fp_pipe[3];

  fp_writeback_collector #(.FP_LATENCY(4), .BUF_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .issueValid(issueValid),
    .issueReady(issueReady),
    .issueDstReg(issueDstReg),
    .issueDstType(issueDstType),
    .issueMask(issueMask),
    .fpStall(fpStall),
    .fpResult(fpResult),
    .wbValid(wbValid),
    .wbReady(wbReady),
    .wbDstReg(wbDstReg),
    .wbDstType(wbDstType),
    .wbMask(wbMask),
    .wbData(wbData),
    .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic Vector_t tagv(input logic [31:0] s);
    return {4{s}};
  endfunction

  task automatic issue(input int dst, input logic typ, input logic [3:0] m, input logic [31:0] d);
    issueValid = 1'b1;
    issueDstReg = REG_BITS'(dst);
    issueDstType = typ;
    issueMask = m;
    issue_data = tagv(d);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_wbValid", wbValid, 0);
    chk("rst_issueReady", issueReady, 1);
    chk("rst_fpStall", fpStall, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wbDstReg", wbDstReg, 0);
    chk("rst_wbData", wbData, 0);
    rst = 1'b0;
    // single issue, 3.0 in every lane
    wbReady = 1'b1;
    issue(5, 1'b0, 4'hF, 32'h40400000);
    tick;
    issueValid = 1'b0;
    chk("single_busy", busy, 1);
    chk("single_wb_early", wbValid, 0);
    tick;
    tick;
    tick;
    chk("single_wb_at_L", wbValid, 0);
    tick;
    chk("single_wbValid", wbValid, 1);
    chk("single_dst", wbDstReg, 5);
    chk("single_mask", wbMask, 4'hF);
    chk("single_data", wbData, tagv(32'h40400000));
    tick;
    chk("single_done_wb", wbValid, 0);
    chk("single_done_busy", busy, 0);
    // six back-to-back issues with writeback blocked
    wbReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      issue(10 + i, i[0], 4'hF, 32'hA0000000 + i);
      tick;
    end
    issueValid = 1'b0;
    tick;
    chk("fill3_fpStall", fpStall, 0);
    tick;
    chk("full_fpStall", fpStall, 1);
    chk("full_issueReady", issueReady, 0);
    chk("full_wbValid", wbValid, 1);
    chk("full_head", wbDstReg, 10);
    tick;
    chk("hold_fpStall", fpStall, 1);
    chk("hold_head", wbDstReg, 10);
    chk("hold_data", wbData, tagv(32'hA0000000));
    wbReady = 1'b1;
    tick;
    chk("pop1_release", fpStall, 0);
    chk("pop1_issueReady", issueReady, 1);
    chk("pop1_head", wbDstReg, 11);
    wbReady = 1'b0;
    tick;
    chk("refill_fpStall", fpStall, 1);
    chk("refill_head", wbDstReg, 11);
    wbReady = 1'b1;
    k = 1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      if (wbValid) begin
        chk("drain_dst", wbDstReg, REG_BITS'(10 + k));
        chk("drain_type", wbDstType, 128'(k & 1));
        chk("drain_data", wbData, tagv(32'hA0000000 + k));
        k++;
      end
      tick;
    end
    chk("drain_count", k, 6);
    chk("drain_wbValid", wbValid, 0);
    chk("drain_busy", busy, 0);
    // zero-mask result between two masked ones is dropped
    issue(20, 1'b0, 4'h3, 32'hC0000020);
    tick;
    issue(21, 1'b0, 4'h0, 32'hC0000021);
    tick;
    issue(22, 1'b1, 4'hC, 32'hC0000022);
    tick;
    issueValid = 1'b0;
    wb_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (wbValid) begin
        if (wb_seen == 0) begin
          chk("mask_first_dst", wbDstReg, 20);
          chk("mask_first_mask", wbMask, 4'h3);
          chk("mask_first_data", wbData, tagv(32'hC0000020));
        end else begin
          chk("mask_second_dst", wbDstReg, 22);
          chk("mask_second_mask", wbMask, 4'hC);
          chk("mask_second_data", wbData, tagv(32'hC0000022));
        end
        wb_seen++;
      end
      tick;
    end
    chk("mask_wb_count", wb_seen, 2);
    chk("mask_busy", busy, 0);
    // reset with three in flight and two buffered
    wbReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(1 + i, 1'b0, 4'hF, 32'hB0000000 + i);
      tick;
    end
    issueValid = 1'b0;
    tick;
    chk("pre_rst_wbValid", wbValid, 1);
    chk("pre_rst_head", wbDstReg, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick;
    chk("post_rst_wbValid", wbValid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_fpStall", fpStall, 0);
    chk("post_rst_issueReady", issueReady, 1);
    chk("post_rst_wbDstReg", wbDstReg, 0);
    chk("post_rst_wbData", wbData, 0);
    rst = 1'b0;
    wbReady = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (wbValid || busy) stale++;
    end
    chk("post_rst_stale", stale, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
